// File: rtl/ddc_accumulator.sv
// Integrate-and-dump stage behind the DDC core: sums frames of I/Q samples into
// 48-bit accumulators and queues each frame result on a backpressured stream.
module ddc_accumulator #(
    parameter int IN_WIDTH    = 27,
    parameter int ACC_WIDTH   = 48,
    parameter int LEN_WIDTH   = 16,
    parameter int DEFAULT_LEN = 1024
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_aresetn,
    input  logic [63:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic [LEN_WIDTH-1:0] s_axis_len_tdata,
    input  logic                 s_axis_len_tvalid,
    output logic [127:0]         m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overflow
);

    localparam int PAD_WIDTH = 64 - ACC_WIDTH;

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] q;
        logic signed [ACC_WIDTH-1:0] i;
    } result_t;

    logic signed [ACC_WIDTH-1:0] sample_i;
    logic signed [ACC_WIDTH-1:0] sample_q;
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [LEN_WIDTH-1:0]        pending_len;
    logic [LEN_WIDTH-1:0]        active_len;
    logic [LEN_WIDTH-1:0]        cnt;
    logic [LEN_WIDTH-1:0]        frame_len;
    logic                        frame_start;
    logic                        dump;
    result_t                     sum;

    result_t                     fifo_mem [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  fifo_count;
    logic                        fifo_full;
    logic                        pop;
    logic                        push;
    logic                        drop;
    result_t                     head;

    logic                        unused_bits;
    assign unused_bits = ^{s_axis_tdata[63:32+IN_WIDTH], s_axis_tdata[31:IN_WIDTH]};

    assign sample_i = {{(ACC_WIDTH-IN_WIDTH){s_axis_tdata[IN_WIDTH-1]}},
                       s_axis_tdata[IN_WIDTH-1:0]};
    assign sample_q = {{(ACC_WIDTH-IN_WIDTH){s_axis_tdata[32+IN_WIDTH-1]}},
                       s_axis_tdata[32+IN_WIDTH-1:32]};

    // A frame start uses the pending length as it stood before any same-cycle write.
    assign frame_start = s_axis_tvalid && (cnt == '0);
    assign frame_len   = frame_start ? pending_len : active_len;
    assign dump        = s_axis_tvalid && (cnt == frame_len - LEN_WIDTH'(1));

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        sum   = '0;
        sum.i = (frame_start ? '0 : acc_i) + sample_i;
        sum.q = (frame_start ? '0 : acc_q) + sample_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            pending_len <= LEN_WIDTH'(DEFAULT_LEN);
            active_len  <= LEN_WIDTH'(DEFAULT_LEN);
            cnt         <= '0;
            acc_i       <= '0;
            acc_q       <= '0;
        end else begin
            if (s_axis_len_tvalid) begin
                pending_len <= (s_axis_len_tdata == '0) ? LEN_WIDTH'(1) : s_axis_len_tdata;
            end
            if (s_axis_tvalid) begin
                if (frame_start) begin
                    active_len <= pending_len;
                end
                if (dump) begin
                    cnt   <= '0;
                    acc_i <= '0;
                    acc_q <= '0;
                end else begin
                    cnt   <= cnt + LEN_WIDTH'(1);
                    acc_i <= sum.i;
                    acc_q <= sum.q;
                end
            end
        end
    end

    // A full queue still accepts a result when the head leaves in the same cycle.
    assign fifo_full = (fifo_count == 2'd2);
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign push      = dump && (!fifo_full || pop);
    assign drop      = dump && fifo_full && !pop;

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: queue storage is not reset; its contents are only visible through
    // the count, which is.
    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sum;
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid
                         ? {{PAD_WIDTH{head.q[ACC_WIDTH-1]}}, head.q,
                            {PAD_WIDTH{head.i[ACC_WIDTH-1]}}, head.i}
                         : 128'd0;

endmodule

// File: tb/tb_ddc_accumulator.sv
// Randomised and directed bench for ddc_accumulator against a frame-level
// reference model (sample lists summed with plain integer arithmetic).
module tb_ddc_accumulator;

    localparam int DEFAULT_LEN = 1024;

    logic         clk = 1'b0;
    logic         rstn;
    logic [63:0]  s_tdata;
    logic         s_tvalid;
    logic [15:0]  len_tdata;
    logic         len_tvalid;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int beats  = 0;

    // Reference model state
    int           pend_len;
    int           flen;
    int           fcount;
    longint       fsum_i;
    longint       fsum_q;
    logic [127:0] exp_q[$];
    bit           exp_ovf;

    ddc_accumulator dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rstn),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_len_tdata  (len_tdata),
        .s_axis_len_tvalid (len_tvalid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .overflow          (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic put(input bit v, input longint i, input longint q);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[26:0]  = i[26:0];
        d[58:32] = q[26:0];
        s_tdata  = d;
        s_tvalid = v;
    endtask

    // Advance the model by one clock edge using the current inputs, then let
    // the DUT take the same edge and compare every output.
    task automatic cycle();
        logic [63:0]  d;
        logic [26:0]  fi;
        logic [26:0]  fq;
        logic [127:0] exp_data;
        bit           pop;
        d = s_tdata;
        if (m_tvalid && m_tready) beats++;
        if (!rstn) begin
            pend_len = DEFAULT_LEN;
            fcount   = 0;
            fsum_i   = 0;
            fsum_q   = 0;
            exp_q.delete();
            exp_ovf  = 1'b0;
        end else begin
            pop = (exp_q.size() != 0) && m_tready;
            if (pop) void'(exp_q.pop_front());
            if (s_tvalid) begin
                fi = d[26:0];
                fq = d[58:32];
                if (fcount == 0) begin
                    flen   = pend_len;
                    fsum_i = 0;
                    fsum_q = 0;
                end
                fsum_i += longint'(signed'(fi));
                fsum_q += longint'(signed'(fq));
                fcount++;
                if (fcount == flen) begin
                    fcount = 0;
                    if (exp_q.size() < 2) exp_q.push_back({64'(fsum_q), 64'(fsum_i)});
                    else                  exp_ovf = 1'b1;
                end
            end
            if (len_tvalid) pend_len = (len_tdata == 0) ? 1 : int'(len_tdata);
        end
        @(posedge clk);
        #1;
        exp_data = (exp_q.size() != 0) ? exp_q[0] : 128'd0;
        check("tvalid",   {127'd0, m_tvalid}, {127'd0, exp_q.size() != 0});
        check("tdata",    m_tdata, exp_data);
        check("overflow", {127'd0, ovf}, {127'd0, exp_ovf});
    endtask

    task automatic write_len(input int len);
        put(1'b0, 0, 0);
        len_tdata  = 16'(len);
        len_tvalid = 1'b1;
        cycle();
        len_tvalid = 1'b0;
    endtask

    initial begin
        int b0;
        rstn       = 1'b0;
        len_tdata  = '0;
        len_tvalid = 1'b0;
        m_tready   = 1'b1;
        put(1'b0, 0, 0);
        cycle();
        cycle();
        check("reset tvalid",   {127'd0, m_tvalid}, 128'd0);
        check("reset tdata",    m_tdata, 128'd0);
        check("reset overflow", {127'd0, ovf}, 128'd0);
        rstn = 1'b1;
        cycle();

        // Length 4: I=1..4, Q=-1..-4
        write_len(4);
        for (int k = 1; k <= 4; k++) begin
            put(1'b1, k, -k);
            if (k == 4) begin
                cycle();
                check("len4 sum", m_tdata,
                      128'hFFFF_FFFF_FFFF_FFF6_0000_0000_0000_000A);
            end else begin
                cycle();
                check("len4 no early beat", {127'd0, m_tvalid}, 128'd0);
            end
        end
        put(1'b0, 0, 0);
        cycle();
        check("len4 single beat", {127'd0, m_tvalid}, 128'd0);

        // Longest frame with extreme inputs
        write_len(65535);
        for (int k = 0; k < 65535; k++) begin
            put(1'b1, -longint'(67108864), 67108863);
            cycle();
        end
        check("max frame I", {64'd0, m_tdata[63:0]}, {64'd0, 64'(-longint'(67108864) * 65535)});
        check("max frame Q", {64'd0, m_tdata[127:64]}, {64'd0, 64'(longint'(67108863) * 65535)});
        put(1'b0, 0, 0);
        cycle();

        // Length 1 with downstream stalled: third result dropped
        write_len(1);
        m_tready = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            put(1'b1, k, 0);
            cycle();
        end
        check("drop overflow", {127'd0, ovf}, 128'd1);
        check("drop head",     m_tdata, 128'd7);
        put(1'b0, 0, 0);
        m_tready = 1'b1;
        cycle();
        check("drain second", m_tdata, 128'd8);
        cycle();
        check("drain empty", {127'd0, m_tvalid}, 128'd0);

        // Length change mid-frame only applies to the following frames
        write_len(4);
        b0 = beats;
        for (int k = 0; k < 2; k++) begin
            put(1'b1, $urandom_range(1000), $urandom_range(1000));
            cycle();
        end
        write_len(2);
        for (int k = 0; k < 6; k++) begin
            put(1'b1, $urandom_range(1000), -longint'($urandom_range(1000)));
            cycle();
            put(1'b0, 0, 0);
            repeat ($urandom_range(2)) cycle();
        end
        repeat (3) cycle();
        check("len change beats", 128'(beats - b0), 128'd3);

        // Reset mid-frame returns length to the default
        write_len(4);
        for (int k = 0; k < 3; k++) begin
            put(1'b1, 1, 1);
            cycle();
        end
        put(1'b0, 0, 0);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            put(1'b1, 1, 1);
            cycle();
        end
        check("reset frame sum", m_tdata, {64'd1024, 64'd1024});
        check("reset overflow clear", {127'd0, ovf}, 128'd0);
        put(1'b0, 0, 0);
        cycle();

        // Zero length behaves as one
        write_len(0);
        put(1'b1, 5, 0);
        cycle();
        check("len0 first", m_tdata, 128'd5);
        put(1'b1, 6, 0);
        cycle();
        check("len0 second", m_tdata, 128'd6);
        put(1'b0, 0, 0);
        cycle();

        // Random traffic, length writes and backpressure
        for (int k = 0; k < 3000; k++) begin
            put($urandom_range(3) != 0,
                longint'(signed'(27'($urandom))), longint'(signed'(27'($urandom))));
            len_tvalid = ($urandom_range(40) == 0);
            len_tdata  = 16'($urandom_range(5));
            m_tready   = ($urandom_range(2) != 0);
            cycle();
        end
        len_tvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
